udp_frame_writer: RTL and testbench
===================================

Name: udp_frame_writer

Overview:
- Host-to-DRAM direction of the UDP frame path: receives UDP packets from the UDP core's receive stream, validates them, and buffers one packet's pixel payload.
- Kicks the DRAM write engine to store the payload at the frame-buffer offset carried in the packet.
- Control packets switch the write bank so the host can double-buffer frames. Sits between the UDP core receive port and the DRAM write-command/data port, in the clk domain.

Parameters:
- MAX_WORDS, 64, maximum payload data words per packet; also the buffer depth.
- FRAME_WORDS, 1440000, words per frame (1600*900); offset+N beyond this is rejected.
- BANK1_BASE, 32'h0100_0000, byte base address of bank 1. Bank 0 base is 32'h0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- r_req  in  1  UDP core has a packet pending.
- r_ack  out  1  block ready to accept a packet.
- r_enable  in  1  high for consecutive cycles, one word per cycle, for the whole packet.
- r_data  in  32  packet word.
- kick  out  1  one-cycle DRAM write start pulse.
- busy  in  1  DRAM writer busy; rises the cycle after kick and stays high until done.
- write_addr  out  32  byte address of the write.
- write_num  out  32  words to write.
- buf_re  in  1  DRAM writer pops one payload word.
- buf_dout  out  32  payload word, valid the cycle after buf_re.
- frame_select  out  1  current write bank.
- pkt_cnt  out  16  accepted data packets, saturating.
- err_cnt  out  16  dropped packets, saturating.

Behaviour:
- Reset values: state S_IDLE, kick 0, write_addr 0, write_num 0, buf_dout 0, frame_select 0, pkt_cnt 0, err_cnt 0, pointers 0. Reset mid-operation aborts everything and discards the buffer.
- Packet format: words 0-3 are header (dst, src, ports, size). size[15:0] holds payload bytes. Word 4 is the info word. Words 5 onward are data.
- The info word's bit31 selects the packet type:
  - bit31=0: data packet; bits 30:0 give the word offset.
  - bit31=1: control packet; toggles frame_select.
- Handshake: r_ack = (state==S_IDLE), combinational. The UDP core starts r_enable only after it has seen r_ack. A packet ends when r_enable falls.
- N = (size-4)>>2. The packet is valid only if:
  - size[1:0]==0, and
  - 1<=N<=MAX_WORDS for data packets (N==0 for control), and
  - offset+N<=FRAME_WORDS.
- States:
  - S_IDLE: on r_enable, latch word 0 and go to S_HEADER (hdr_cnt=1).
  - S_HEADER: latch words 1-3; after word 3, go to S_INFO.
  - S_INFO: latch offset/type and check validity. Invalid -> S_DROP. Control -> S_SWITCH. Data -> S_DATA.
  - S_DATA: write r_data to buf[wptr] and increment wptr.
    - If r_enable falls with wptr<N -> S_DROP.
    - If r_enable is still high when wptr==N -> S_DROP (overlong packet).
    - If r_enable falls exactly at wptr==N -> S_KICK.
  - S_DROP: wait for r_enable==0, increment err_cnt, go to S_IDLE.
  - S_SWITCH: toggle frame_select, then S_IDLE.
  - S_KICK: when busy==0, drive write_addr=(offset<<2)+(frame_select?BANK1_BASE:0), write_num=N, pulse kick, reset rptr, go to S_WAIT_HI.
  - S_WAIT_HI: go to S_WAIT_LO when busy==1.
  - S_WAIT_LO: when busy==0, increment pkt_cnt, go to S_IDLE.
- Buffer reads: buf_re reads buf[rptr] into buf_dout with 1-cycle latency and increments rptr. buf_re outside S_WAIT_HI/S_WAIT_LO is ignored.
- Packets are never written partially to DRAM; a drop leaves DRAM untouched.
- Address arithmetic is 32-bit and wraps modulo 2^32; the offset check prevents overflow for legal frames.

Decomposition:
- Package udp_frame_pkg holds:
  - state enum;
  - header word count 4;
  - info-type bit index 31;
  - OFFSET_END/FRAME_WORDS;
  - bank base constants, shared with the transmit streamer.
- One sub-module: udp_rx_payload_buf, a MAX_WORDS x 32 single-clock RAM with write pointer, read pointer and registered read port.

Test Plan:
- Data packet, size=0x104 (N=64), offset=0x40, frame_select=0 -> one kick, write_addr=0x100, write_num=64; buf_dout returns the 64 words in order; pkt_cnt=1.
- Control packet, size=4, info=0x8000_0000 -> frame_select=1, no kick. A following data packet at offset 0 -> write_addr=0x0100_0000.
- size=0x104 but r_enable drops after 30 data words -> no kick, err_cnt=1, r_ack reasserts.
- size=0x14 (N=4) with 6 data words -> drop; 5-word packet then accepted normally.
- offset=1439990 with N=64 -> drop, err_cnt increments, DRAM untouched.
- Packet completes while busy=1 from a prior write -> kick is held until busy=0. rst asserted in S_WAIT_LO -> all outputs return to reset values.

Source files
------------

// File: rtl/udp_frame_writer_pkg.sv
// Shared definitions for the UDP frame path: writer FSM states, packet
// layout constants, frame geometry and DRAM bank bases. The transmit
// streamer uses the same bank bases and frame size.
package udp_frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEADER,
    S_INFO,
    S_DATA,
    S_DROP,
    S_SWITCH,
    S_KICK,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  // Four header words (dst, src, ports, size) precede the info word.
  localparam int HDR_WORDS     = 4;
  // Info word bit that marks a control (bank switch) packet.
  localparam int INFO_TYPE_BIT = 31;

  localparam int MAX_WORDS_DEF = 64;
  // Words per frame (1600 x 900). A data packet may end exactly here.
  localparam int FRAME_WORDS   = 1600 * 900;
  localparam int OFFSET_END    = FRAME_WORDS;

  localparam logic [31:0] BANK0_BASE     = 32'h0000_0000;
  localparam logic [31:0] BANK1_BASE_DEF = 32'h0100_0000;

endpackage

// File: rtl/udp_frame_writer_if.sv
// Bus bundle for udp_frame_writer.
//   Receive stream : r_req, r_ack, r_enable, r_data (UDP core -> writer)
//   DRAM write port: kick, write_addr, write_num (writer -> DRAM engine),
//                    busy, buf_re (DRAM engine -> writer), buf_dout (payload)
// slave  : the writer's view.
// master : the view of the UDP core and DRAM engine together.
interface udp_frame_writer_if;
  logic        r_req;
  logic        r_ack;
  logic        r_enable;
  logic [31:0] r_data;
  logic        kick;
  logic        busy;
  logic [31:0] write_addr;
  logic [31:0] write_num;
  logic        buf_re;
  logic [31:0] buf_dout;

  modport slave (
    input  r_req, r_enable, r_data, busy, buf_re,
    output r_ack, kick, write_addr, write_num, buf_dout
  );

  modport master (
    output r_req, r_enable, r_data, busy, buf_re,
    input  r_ack, kick, write_addr, write_num, buf_dout
  );
endinterface

// File: rtl/udp_rx_payload_buf.sv
// Single-clock payload buffer holding one packet's data words.
//   wr_en/wr_data : store a word at the write pointer and advance it
//   wr_clr        : rewind the write pointer (start of a new payload)
//   wr_count      : words stored so far (0..DEPTH)
//   rd_en         : load the word at the read pointer into rd_data, advance
//   rd_clr        : rewind the read pointer (start of a DRAM transfer)
//   rd_data       : registered read data, valid the cycle after rd_en
module udp_rx_payload_buf #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       wr_clr,
  output logic [$clog2(DEPTH+1)-1:0] wr_count,
  input  logic                       rd_en,
  input  logic                       rd_clr,
  output logic [31:0]                rd_data
);
  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rptr;

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers are cleared, so a reset discards the contents logically and
  // the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count[ADDR_W-1:0]] <= wr_data;
  end

  // NOTE: all sequential state is assigned with <= so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      rptr     <= '0;
      rd_data  <= '0;
    end else begin
      if (wr_clr)     wr_count <= '0;
      else if (wr_en) wr_count <= wr_count + PTR_W'(1);

      if (rd_clr) begin
        rptr <= '0;
      end else if (rd_en) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/udp_frame_writer.sv
// UDP frame writer: receives packets from the UDP core, validates them,
// buffers one packet's pixel payload and hands it to the DRAM write engine
// at the frame-buffer offset carried in the packet. Control packets toggle
// the write bank for host-side double buffering.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : receive stream and DRAM write port (udp_frame_writer_if)
//   frame_select : current write bank (0 -> base 0, 1 -> BANK1_BASE)
//   pkt_cnt      : accepted data packets, saturating
//   err_cnt      : dropped packets, saturating
module udp_frame_writer
  import udp_frame_pkg::*;
#(
  parameter int          MAX_WORDS   = MAX_WORDS_DEF,
  parameter int          FRAME_WORDS = OFFSET_END,
  parameter logic [31:0] BANK1_BASE  = BANK1_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  udp_frame_writer_if.slave bus,
  output logic              frame_select,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);
  localparam int          PTR_W     = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_W32   = 32'(MAX_WORDS);
  localparam logic [31:0] FRAME_W32 = 32'(FRAME_WORDS);

  state_t           state;
  logic [1:0]       hdr_cnt;
  logic [15:0]      size_q;
  logic [29:0]      offset_q;
  logic [PTR_W-1:0] num_q;
  logic [PTR_W-1:0] wr_count;

  logic [15:0] size_m4;
  logic [13:0] n_words;
  logic [31:0] n_words32;
  logic [31:0] end_word;
  logic        is_ctrl;
  logic        info_ok;
  logic        buf_we, buf_wclr, buf_rd, buf_rclr;

  // Payload length from the UDP size field: N = (size - 4) >> 2. Since
  // size - 4 keeps the low two bits of size, they double as the alignment
  // check. Offset is 31 bits and N at most 14, so end_word cannot overflow.
  assign size_m4   = size_q - 16'd4;
  assign n_words   = size_m4[15:2];
  assign n_words32 = {18'd0, n_words};
  assign end_word  = {1'b0, bus.r_data[30:0]} + n_words32;
  assign is_ctrl   = bus.r_data[INFO_TYPE_BIT];

  // NOTE: info_ok gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    info_ok = 1'b0;
    if (size_m4[1:0] == 2'b00) begin
      if (is_ctrl) info_ok = (n_words == 14'd0);
      else         info_ok = (n_words != 14'd0) && (n_words32 <= MAX_W32) &&
                             (end_word <= FRAME_W32);
    end
  end

  assign bus.r_ack = (state == S_IDLE);

  // A word arriving when the buffer already holds N words is an overlong
  // packet; it is not stored and the FSM drops the packet.
  assign buf_we   = (state == S_DATA) && bus.r_enable && (wr_count != num_q);
  assign buf_wclr = (state == S_INFO);
  assign buf_rclr = (state == S_KICK) && !bus.busy;
  assign buf_rd   = bus.buf_re && ((state == S_WAIT_HI) || (state == S_WAIT_LO));

  udp_rx_payload_buf #(.DEPTH(MAX_WORDS)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_we),
    .wr_data  (bus.r_data),
    .wr_clr   (buf_wclr),
    .wr_count (wr_count),
    .rd_en    (buf_rd),
    .rd_clr   (buf_rclr),
    .rd_data  (bus.buf_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      hdr_cnt        <= '0;
      size_q         <= '0;
      offset_q       <= '0;
      num_q          <= '0;
      bus.kick       <= 1'b0;
      bus.write_addr <= '0;
      bus.write_num  <= '0;
      frame_select   <= 1'b0;
      pkt_cnt        <= '0;
      err_cnt        <= '0;
    end else begin
      bus.kick <= 1'b0;
      case (state)
        S_IDLE: begin
          // Word 0 (dst) carries nothing this block uses.
          if (bus.r_enable) begin
            hdr_cnt <= 2'd1;
            state   <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!bus.r_enable) begin
            state <= S_DROP;  // truncated header
          end else begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'(HDR_WORDS - 1)) begin
              size_q <= bus.r_data[15:0];
              state  <= S_INFO;
            end
          end
        end
        S_INFO: begin
          if (!bus.r_enable || !info_ok) begin
            state <= S_DROP;
          end else if (is_ctrl) begin
            state <= S_SWITCH;
          end else begin
            offset_q <= bus.r_data[29:0];
            num_q    <= n_words[PTR_W-1:0];
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.r_enable) begin
            if (wr_count == num_q) state <= S_DROP;
          end else begin
            state <= (wr_count == num_q) ? S_KICK : S_DROP;
          end
        end
        S_DROP: begin
          if (!bus.r_enable) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            state <= S_IDLE;
          end
        end
        S_SWITCH: begin
          frame_select <= ~frame_select;
          state        <= S_IDLE;
        end
        S_KICK: begin
          if (!bus.busy) begin
            bus.write_addr <= {offset_q, 2'b00} +
                              (frame_select ? BANK1_BASE : BANK0_BASE);
            bus.write_num  <= 32'(num_q);
            bus.kick       <= 1'b1;
            state          <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (bus.busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!bus.busy) begin
            if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_frame_writer.sv
`timescale 1ns/1ps
module tb_udp_frame_writer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] num;
  } kick_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_select;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic        model_busy   = 1'b0;
  logic        ext_busy     = 1'b0;
  logic        model_active = 1'b0;

  int checks     = 0;
  int failures   = 0;
  int kick_count = 0;

  kick_t       exp_kick [$];
  logic [31:0] exp_word [$];

  always #5 clk = ~clk;

  udp_frame_writer_if bus();
  assign bus.busy = model_busy | ext_busy;

  udp_frame_writer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .frame_select (frame_select),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every kick and every read-back word.
  initial begin
    logic        re_q;
    kick_t       k;
    logic [31:0] w;
    forever begin
      @(posedge clk);
      re_q = bus.buf_re;
      @(negedge clk);
      if (!rst) begin
        if (bus.kick) begin
          kick_count++;
          if (exp_kick.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_kick: addr 0x%08h num %0d", bus.write_addr, bus.write_num);
          end else begin
            k = exp_kick.pop_front();
            check("kick_addr", bus.write_addr, k.addr);
            check("kick_num", bus.write_num, k.num);
          end
        end
        if (re_q) begin
          if (exp_word.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word: got 0x%08h", bus.buf_dout);
          end else begin
            w = exp_word.pop_front();
            check("buf_dout", bus.buf_dout, w);
          end
        end
      end
    end
  end

  // DRAM write engine model: busy the cycle after kick, pops write_num words.
  initial begin
    int n;
    bus.buf_re = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.kick) begin
        model_active = 1'b1;
        n = (bus.write_num > 32'd64) ? 64 : int'(bus.write_num);
        @(posedge clk); #1;
        model_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
          bus.buf_re = 1'b1;
          @(posedge clk); #1;
        end
        bus.buf_re = 1'b0;
        repeat (2) @(posedge clk);
        #1 model_busy = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_pkt(input logic [31:0] addr, input int num, input logic [31:0] base);
    kick_t k;
    k.addr = addr;
    k.num  = 32'(num);
    exp_kick.push_back(k);
    for (int i = 0; i < num; i++) exp_word.push_back(base + 32'(i));
  endtask

  task automatic send_pkt(input logic [15:0] size, input logic [31:0] info,
                          input int ndata, input logic [31:0] base);
    int t = 0;
    bus.r_req = 1'b1;
    @(negedge clk);
    while (!bus.r_ack && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("r_ack_before_pkt", 32'(bus.r_ack), 32'd1);
    @(posedge clk); #1;
    bus.r_req    = 1'b0;
    bus.r_enable = 1'b1;
    bus.r_data   = 32'hC0A8_0001;
    @(posedge clk); #1 bus.r_data = 32'hC0A8_0002;
    @(posedge clk); #1 bus.r_data = 32'h1F90_1F91;
    @(posedge clk); #1 bus.r_data = {16'h0000, size};
    @(posedge clk); #1 bus.r_data = info;
    for (int i = 0; i < ndata; i++) begin
      @(posedge clk); #1 bus.r_data = base + 32'(i);
    end
    @(posedge clk); #1;
    bus.r_enable = 1'b0;
    bus.r_data   = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (3) @(negedge clk);
    while ((!bus.r_ack || model_active) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", {30'd0, bus.r_ack, model_active}, 32'd2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_r_ack"}, 32'(bus.r_ack), 32'd1);
    check({tag, "_kick"}, 32'(bus.kick), 32'd0);
    check({tag, "_write_addr"}, bus.write_addr, 32'd0);
    check({tag, "_write_num"}, bus.write_num, 32'd0);
    check({tag, "_buf_dout"}, bus.buf_dout, 32'd0);
    check({tag, "_frame_select"}, 32'(frame_select), 32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    int k0;
    int t;
    bus.r_req    = 1'b0;
    bus.r_enable = 1'b0;
    bus.r_data   = '0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Full 64-word data packet into bank 0 at offset 0x40.
    expect_pkt(32'h0000_0100, 64, 32'hA000_0000);
    send_pkt(16'h0104, 32'h0000_0040, 64, 32'hA000_0000);
    wait_idle();
    check("pkt_cnt_1", 32'(pkt_cnt), 32'd1);
    check("err_cnt_0", 32'(err_cnt), 32'd0);

    // Control packet toggles the bank without a kick.
    k0 = kick_count;
    send_pkt(16'h0004, 32'h8000_0000, 0, 32'h0);
    wait_idle();
    check("frame_select_1", 32'(frame_select), 32'd1);
    check("ctrl_no_kick", 32'(kick_count), 32'(k0));

    // Data packet at offset 0 now lands in bank 1.
    expect_pkt(32'h0100_0000, 4, 32'hB000_0000);
    send_pkt(16'h0014, 32'h0000_0000, 4, 32'hB000_0000);
    wait_idle();
    check("pkt_cnt_2", 32'(pkt_cnt), 32'd2);

    // Truncated payload: 30 of 64 words.
    k0 = kick_count;
    send_pkt(16'h0104, 32'h0000_0000, 30, 32'hD000_0000);
    wait_idle();
    check("short_err_cnt", 32'(err_cnt), 32'd1);
    check("short_r_ack", 32'(bus.r_ack), 32'd1);
    check("short_no_kick", 32'(kick_count), 32'(k0));

    // Overlong payload: 6 words for N=4, then a clean 5-word packet.
    send_pkt(16'h0014, 32'h0000_0000, 6, 32'hD100_0000);
    wait_idle();
    check("long_err_cnt", 32'(err_cnt), 32'd2);
    expect_pkt(32'h0100_0040, 5, 32'hC000_0000);
    send_pkt(16'h0018, 32'h0000_0010, 5, 32'hC000_0000);
    wait_idle();
    check("pkt_cnt_3", 32'(pkt_cnt), 32'd3);

    // Frame-end boundary: 1439990+64 overruns, 1439936+64 fits exactly.
    send_pkt(16'h0104, 32'd1439990, 64, 32'hD200_0000);
    wait_idle();
    check("range_err_cnt", 32'(err_cnt), 32'd3);
    check("range_no_kick", 32'(kick_count), 32'(k0 + 1));
    expect_pkt(32'h0157_E300, 64, 32'hE000_0000);
    send_pkt(16'h0104, 32'd1439936, 64, 32'hE000_0000);
    wait_idle();
    check("pkt_cnt_4", 32'(pkt_cnt), 32'd4);

    // Size not a multiple of 4.
    send_pkt(16'h0015, 32'h0000_0000, 4, 32'hD300_0000);
    wait_idle();
    check("misaligned_err_cnt", 32'(err_cnt), 32'd4);

    // Kick is held while busy is still high from another write.
    ext_busy = 1'b1;
    k0 = kick_count;
    expect_pkt(32'h0100_0080, 4, 32'h5000_0000);
    send_pkt(16'h0014, 32'h0000_0020, 4, 32'h5000_0000);
    repeat (10) @(negedge clk);
    check("held_no_kick", 32'(kick_count), 32'(k0));
    check("held_r_ack", 32'(bus.r_ack), 32'd0);
    @(posedge clk); #1 ext_busy = 1'b0;
    wait_idle();
    check("held_kicked", 32'(kick_count), 32'(k0 + 1));
    check("pkt_cnt_5", 32'(pkt_cnt), 32'd5);

    // Reset while waiting for busy to fall.
    expect_pkt(32'h0100_0014, 2, 32'h6000_0000);
    send_pkt(16'h000C, 32'h0000_0005, 2, 32'h6000_0000);
    t = 0;
    while (!bus.kick && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_test_kick_seen", 32'(bus.kick), 32'd1);
    ext_busy = 1'b1;
    repeat (2) @(negedge clk);
    t = 0;
    while (model_active && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("wait_lo_r_ack", 32'(bus.r_ack), 32'd0);
    check("wait_lo_pkt_cnt", 32'(pkt_cnt), 32'd5);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("midrst");
    ext_busy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_r_ack", 32'(bus.r_ack), 32'd1);

    check("kicks_drained", 32'(exp_kick.size()), 32'd0);
    check("words_drained", 32'(exp_word.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
